// File: rtl/fft_pkg.sv
// Shared FFT constants, sample type and index bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_DATA_W  = 8;
  localparam int unsigned FFT_N       = 8;
  localparam int unsigned FFT_LOG2N   = 3;
  localparam int unsigned BITREV_MAXW = 6;

  typedef logic [FFT_DATA_W-1:0] sample_t;

  // Reverse the low w bits of v (w <= BITREV_MAXW); upper bits return 0.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] v,
                                                     input int unsigned w);
    logic [BITREV_MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAXW; i++) begin
      if (i < w) r[3'(i)] = v[3'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame buffer: N x DATA_W register file, single write port,
// asynchronous read port, cleared to zero on reset.
module reorder_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [N];

  // Write port: store one sample per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mem <= '{default: '0};
    else if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fft8_reorder_ctrl.sv
// Ping-pong input reorder for the radix-2 FFT: frames are written in
// natural order and read back in bit-reversed order at 1 sample/cycle.
module fft8_reorder_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned N      = FFT_N,
  parameter int unsigned LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last
);

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [LOG2N-1:0]  r_wr_cnt;
  logic [LOG2N-1:0]  r_rd_cnt;

  logic              w_accept;
  logic              w_emit;
  logic              w_wr_last;
  logic              w_rd_last;
  logic              w_we0;
  logic              w_we1;
  logic [LOG2N-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_sel_data;

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;
  assign w_wr_last = (r_wr_cnt == LOG2N'(N - 1));
  assign w_rd_last = (r_rd_cnt == LOG2N'(N - 1));
  assign w_we0     = w_accept & ~r_wr_bank;
  assign w_we1     = w_accept & r_wr_bank;
  assign w_rd_idx  = LOG2N'(bitrev(BITREV_MAXW'(r_rd_cnt), LOG2N));

  reorder_bank #(.DATA_W(DATA_W), .N(N), .AW(LOG2N)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we0),
    .waddr (r_wr_cnt),
    .wdata (in_data),
    .raddr (w_rd_idx),
    .rdata (w_rdata0)
  );

  reorder_bank #(.DATA_W(DATA_W), .N(N), .AW(LOG2N)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we1),
    .waddr (r_wr_cnt),
    .wdata (in_data),
    .raddr (w_rd_idx),
    .rdata (w_rdata1)
  );

  // Write pointer: advance per accept, switch bank after the N-th sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_accept) begin
      r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Read pointer: advance per emit, switch bank after the N-th sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_emit) begin
      r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Full flags: set targets a non-full bank and clear a full one, so a
  // same-cycle set and clear always hit different bits and both apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= '0;
    end else begin
      if (w_accept && w_wr_last) r_full[r_wr_bank] <= 1'b1;
      if (w_emit && w_rd_last)   r_full[r_rd_bank] <= 1'b0;
    end
  end

  // Output mux: bit-reversed read of the draining bank, zero when idle.
  always_comb begin
    w_sel_data = r_rd_bank ? w_rdata1 : w_rdata0;
    out_data   = out_valid ? w_sel_data : '0;
    out_idx    = w_rd_idx;
    out_first  = out_valid & (r_rd_cnt == '0);
    out_last   = out_valid & w_rd_last;
  end

endmodule

// File: tb/tb_fft8_reorder_ctrl.sv
// Bench for fft8_reorder_ctrl: frame-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fft8_reorder_ctrl;
  import fft_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  sample_t    in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  sample_t    out_data;
  logic [2:0] out_idx;
  logic       out_first;
  logic       out_last;

  fft8_reorder_ctrl #(.DATA_W(8), .N(8), .LOG2N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completed frames in natural order, partial frame,
  // position within the draining frame. Output order from a fixed table.
  int      REV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  sample_t done_q[$];
  sample_t part_q[$];
  int      rd_pos = 0;

  // Captured DUT emits for the directed scenarios.
  int log_d[$];
  int log_i[$];
  int log_f[$];
  int log_l[$];

  always @(negedge clk) begin
    bit exp_rdy, exp_v, acc, emit;
    int p;
    if (rst) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_first", int'(out_first), 0);
      chk("rst_out_last", int'(out_last), 0);
      done_q.delete();
      part_q.delete();
      rd_pos = 0;
    end else begin
      exp_rdy = (done_q.size() < 16);
      exp_v   = (done_q.size() >= 8);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(exp_v));
      if (exp_v) begin
        p = REV[rd_pos];
        chk("out_data", int'(out_data), int'(done_q[p]));
        chk("out_idx", int'(out_idx), p);
        chk("out_first", int'(out_first), int'(rd_pos == 0));
        chk("out_last", int'(out_last), int'(rd_pos == 7));
      end else begin
        chk("idle_out_data", int'(out_data), 0);
        chk("idle_out_first", int'(out_first), 0);
        chk("idle_out_last", int'(out_last), 0);
      end
      if (out_valid && out_ready) begin
        log_d.push_back(int'(out_data));
        log_i.push_back(int'(out_idx));
        log_f.push_back(int'(out_first));
        log_l.push_back(int'(out_last));
      end
      emit = exp_v && out_ready;
      acc  = in_valid && exp_rdy;
      if (emit) begin
        rd_pos++;
        if (rd_pos == 8) begin
          rd_pos = 0;
          repeat (8) void'(done_q.pop_front());
        end
      end
      if (acc) begin
        part_q.push_back(in_data);
        if (part_q.size() == 8) begin
          foreach (part_q[k]) done_q.push_back(part_q[k]);
          part_q.delete();
        end
      end
    end
  end

  // Driver: called at posedge+1, applies inputs for one cycle.
  logic last_rdy;
  logic last_ov;
  int   dut_emits = 0;

  task automatic drive(input logic v, input int d, input logic r, output logic acc);
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = r;
    @(negedge clk);
    acc      = v && in_ready;
    last_rdy = in_ready;
    last_ov  = out_valid;
    if (out_valid && r) dut_emits++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    repeat (n) drive(1'b0, 0, r, a);
  endtask

  task automatic send_seq(input string name, input int base, input int cnt, input logic r);
    logic a;
    int   sent = 0;
    int   budget = cnt * 10 + 20;
    while (sent < cnt && budget > 0) begin
      drive(1'b1, base + sent, r, a);
      if (a) sent++;
      budget--;
    end
    if (sent < cnt) chk({name, "_timeout"}, sent, cnt);
  endtask

  task automatic clear_log();
    log_d.delete(); log_i.delete(); log_f.delete(); log_l.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_d1 [8] = '{10, 14, 12, 16, 11, 15, 13, 17};
    int   exp_i1 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   exp_d2 [8] = '{64, 68, 66, 70, 65, 69, 67, 71};
    logic a;
    int   gaps, first_v, last_v, n_valid, cnt, emits0, idx, budget;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single frame 10..17.
    clear_log();
    send_seq("single", 10, 8, 1'b1);
    idle(10, 1'b1);
    chk("single_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("single_data", log_d[i], exp_d1[i]);
        chk("single_idx", log_i[i], exp_i1[i]);
        chk("single_first", log_f[i], int'(i == 0));
        chk("single_last", log_l[i], int'(i == 7));
      end
    end

    // Back-to-back: 4 frames continuous.
    gaps = 0; first_v = -1; last_v = -1; n_valid = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c < 32, 32 + c, 1'b1, a);
      if (c < 32 && !a) gaps++;
      if (last_ov) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        n_valid++;
      end
    end
    chk("b2b_in_ready_drops", gaps, 0);
    chk("b2b_first_valid", first_v, 8);
    chk("b2b_valid_count", n_valid, 32);
    chk("b2b_last_valid", last_v, 39);

    // Full backpressure.
    send_seq("bp_fill", 80, 16, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 96, 1'b0, a);
      chk("bp_stall_accept", int'(a), 0);
      chk("bp_stall_ready", int'(last_rdy), 0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 0, 1'b1, a);
      chk("bp_drain_ready", int'(last_rdy), 0);
      chk("bp_drain_valid", int'(last_ov), 1);
    end
    drive(1'b0, 0, 1'b0, a);
    chk("bp_ready_back", int'(last_rdy), 1);
    idle(10, 1'b1);

    // Reset mid-operation.
    send_seq("rst_pre", 112, 13, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    idle(2, 1'b0);
    rst = 1'b0;
    clear_log();
    send_seq("rst_post", 64, 8, 1'b1);
    idle(10, 1'b1);
    chk("rst_post_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("rst_post_data", log_d[i], exp_d2[i]);
    end

    // Partial frame.
    send_seq("partial", 144, 7, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 0, 1'b1, a);
      if (last_ov) cnt++;
    end
    chk("partial_no_valid", cnt, 0);
    drive(1'b1, 151, 1'b1, a);
    chk("partial_8th_accept", int'(a), 1);
    drive(1'b0, 0, 1'b1, a);
    chk("partial_release", int'(last_ov), 1);
    idle(10, 1'b1);

    // Random stalls over 20 frames.
    emits0 = dut_emits;
    idx = 0;
    budget = 3000;
    while (idx < 160 && budget > 0) begin
      drive(1'($urandom % 2), (idx * 7 + 3) & 255, 1'($urandom % 2), a);
      if (a) idx++;
      budget--;
    end
    chk("rand_sent", idx, 160);
    idle(20, 1'b1);
    chk("rand_emitted", dut_emits - emits0, 160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft8_reorder_ctrl.md
# fft8_reorder_ctrl

Streaming input-reorder controller for the radix-2 pipelined FFT. Accepts time-domain samples one per cycle in natural order over a valid/ready handshake and emits each N-point frame in bit-reversed order: for N=8, 0,4,2,6,1,5,3,7. This is the sequenced equivalent of the 8-to-4 then 4-to-2 even/odd split stages. It sits between the sample source and the first butterfly stage. Two ping-pong banks let one frame fill while the previous frame drains, so throughput is sustained at 1 sample/cycle.

## Interface
Parameters:
- DATA_W, 8, sample width in bits.
- N, 8, frame length; power of two, 4 ≤ N ≤ 64.
- LOG2N, 3, log2(N); must match N.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source holds a sample.
- in_ready  out  1  controller can accept a sample this cycle.
- in_data  in  DATA_W  sample, natural order.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  DATA_W  sample, bit-reversed order; 0 when out_valid=0.
- out_idx  out  LOG2N  natural (input) index of out_data.
- out_first  out  1  first sample of a frame (out_idx=0).
- out_last  out  1  last sample of a frame (out_idx=N-1).

## Operation
- State: bank0/bank1 (N×DATA_W each), full[1:0], wr_bank, wr_cnt[LOG2N-1:0], rd_bank, rd_cnt[LOG2N-1:0].
- Per bank: EMPTY → FILLING (on first write) → FULL (on the N-th write) → DRAINING (while rd_bank points at it) → EMPTY (on the N-th read).
- Accept = in_valid & in_ready. in_ready = !full[wr_bank].
- On accept: bank[wr_bank][wr_cnt] ← in_data; wr_cnt++.
- On the accept with wr_cnt=N-1: set full[wr_bank], toggle wr_bank, wr_cnt ← 0.
- out_valid = full[rd_bank].
- Output mapping: out_idx = bitrev(rd_cnt); out_data = bank[rd_bank][out_idx].
- Output flags: out_first = out_valid & (rd_cnt=0); out_last = out_valid & (rd_cnt=N-1).
- Emit = out_valid & out_ready. On emit: rd_cnt++.
- On the emit with rd_cnt=N-1: clear full[rd_bank], toggle rd_bank, rd_cnt ← 0.
- Set and clear of full[] in the same cycle always target different banks, and both take effect.
- Both banks full: in_ready=0. Input stalls until the draining bank completes its N-th emit. in_ready rises the cycle after that emit.
- Both banks empty: out_valid=0. out_ready is ignored.
- A partial frame is never emitted. Backpressure on either side holds all pointers.
- Reset (any time, including mid-frame): full=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, bank contents 0. A partial or undrained frame is discarded.
- Output values during and after reset: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_first=0, out_last=0.

## Timing
- All outputs are combinational from registered state. There is no combinational path from in_* to out_*.
- Latency: the first sample of a frame is valid the cycle after that frame's N-th accept.
- Steady state, with out_ready held high and in_valid continuous: out_valid runs 1 sample/cycle, lagging the input by N cycles, with no bubbles.
- in_ready depends only on registered full[]. in_valid and out_ready never feed in_ready combinationally.

## Structure
- Shared package fft_pkg holds:
  - FFT_N and FFT_LOG2N constants.
  - a sample_t typedef (DATA_W=8).
  - a bitrev(LOG2N-bit) function, reused by later stage controllers.
- Sub-module reorder_bank, instantiated twice:
  - N×DATA_W register file, one write port (we, waddr, wdata).
  - one asynchronous read port.
  - asynchronous active-high reset to 0.
- Top level holds the pointers, the full flags and the output mux.

## Test plan
- Reset then single frame: send 10,11,…,17 with out_ready=1. Required output: 10,14,12,16,11,15,13,17, out_idx 0,4,2,6,1,5,3,7, out_first on 10, out_last on 17.
- Back-to-back frames: 4 frames continuous with out_ready=1. Required: in_ready never drops, output is gap-free and starts 8 cycles after the first accept.
- Full backpressure: out_ready=0, send 16 samples. Required: in_ready=0 after the 16th accept and the 17th sample stalls. Then raise out_ready for 8 cycles; in_ready returns to 1 the cycle after the 8th emit.
- Random stalls: random in_valid and out_ready at 50% over 20 frames. Required: each frame matches its bit-reversed reference and no sample is dropped or duplicated.
- Reset mid-operation: assert rst after 5 accepts of frame 2 while frame 1 is mid-drain. Required: out_valid=0 immediately. After release, a new frame emits correctly with no residue from the old frames.
- Partial frame: send 7 samples then stop. Required: out_valid stays 0 indefinitely. The 8th sample releases the full frame the following cycle.
